// File: rtl/psg_pkg.sv
// Constants shared by the PSG noise generator and its receive-side checker,
// plus the checker's state encoding.
package psg_pkg;

  localparam int PSG_LFSR_BITS = 17;
  localparam int PSG_LFSR_TAP0 = 0;
  localparam int PSG_LFSR_TAP1 = 3;

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_TRACK   = 2'd1,
    ST_LOCKED  = 2'd2
  } chk_state_e;

endpackage

// File: rtl/lfsr_predict.sv
// Feedback bit of the noise LFSR for a given state: XOR of the two taps,
// forced to 1 when the state is all zero so the register never sticks.
module lfsr_predict #(
  parameter int BITS = 17,
  parameter int TAP0 = 0,
  parameter int TAP1 = 3
) (
  input  logic [BITS-1:0] window_i,
  output logic            fb_o
);

  assign fb_o = (window_i[TAP0] ^ window_i[TAP1]) | ~(|window_i);

endmodule

// File: rtl/noise_lfsr_checker.sv
// Rebuilds the noise LFSR from the observed output bits, predicts each next
// bit and reports lock, per-bit mispredictions and a saturating error count.
module noise_lfsr_checker
  import psg_pkg::*;
#(
  parameter int LFSR_BITS     = PSG_LFSR_BITS,
  parameter int LFSR_TAP0     = PSG_LFSR_TAP0,
  parameter int LFSR_TAP1     = PSG_LFSR_TAP1,
  parameter bit INVERTED_IN   = 1'b1,
  parameter int LOCK_MATCHES  = 32,
  parameter int UNLOCK_MISSES = 4,
  parameter int ERR_BITS      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                strobe,
  input  logic                noise_in,
  input  logic                clear,
  output logic                locked,
  output logic                error,
  output logic [ERR_BITS-1:0] error_count,
  output logic [1:0]          state
);

  localparam int BIT_W   = $clog2(LFSR_BITS);
  localparam int MATCH_W = $clog2(LOCK_MATCHES + 1);
  localparam int MISS_W  = $clog2(UNLOCK_MISSES + 1);

  localparam logic [BIT_W-1:0]    BIT_LAST   = BIT_W'(LFSR_BITS - 1);
  localparam logic [MATCH_W-1:0]  MATCH_LAST = MATCH_W'(LOCK_MATCHES - 1);
  localparam logic [MISS_W-1:0]   MISS_LAST  = MISS_W'(UNLOCK_MISSES - 1);
  localparam logic [ERR_BITS-1:0] ERR_MAX    = '1;

  chk_state_e           state_q;
  logic [LFSR_BITS-1:0] window_q;
  logic [LFSR_BITS-1:0] window_d;
  logic [BIT_W-1:0]     bitcnt_q;
  logic [MATCH_W-1:0]   matchcnt_q;
  logic [MISS_W-1:0]    misscnt_q;
  logic [ERR_BITS-1:0]  error_count_q;
  logic [ERR_BITS-1:0]  error_count_d;
  logic                 locked_q;
  logic                 error_q;

  logic obs_bit;
  logic pred_bit;
  logic hit;

  assign obs_bit = noise_in ^ INVERTED_IN;

  lfsr_predict #(
    .BITS (LFSR_BITS),
    .TAP0 (LFSR_TAP0),
    .TAP1 (LFSR_TAP1)
  ) u_predict (
    .window_i (window_q),
    .fb_o     (pred_bit)
  );

  assign hit           = (pred_bit == obs_bit);
  // The window always takes the observed bit, never the prediction.
  assign window_d      = {obs_bit, window_q[LFSR_BITS-1:1]};
  assign error_count_d = (error_count_q == ERR_MAX) ? error_count_q
                                                    : error_count_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_ACQUIRE;
      window_q      <= '0;
      bitcnt_q      <= '0;
      matchcnt_q    <= '0;
      misscnt_q     <= '0;
      error_count_q <= '0;
      locked_q      <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      error_q <= 1'b0;
      if (strobe) begin
        window_q <= window_d;
        unique case (state_q)
          ST_ACQUIRE: begin
            if (bitcnt_q == BIT_LAST) begin
              state_q    <= ST_TRACK;
              bitcnt_q   <= '0;
              matchcnt_q <= '0;
            end else begin
              bitcnt_q <= bitcnt_q + 1'b1;
            end
          end
          ST_TRACK: begin
            if (hit) begin
              matchcnt_q <= matchcnt_q + 1'b1;
              if (matchcnt_q == MATCH_LAST) begin
                state_q   <= ST_LOCKED;
                locked_q  <= 1'b1;
                misscnt_q <= '0;
              end
            end else begin
              error_q  <= 1'b1;
              state_q  <= ST_ACQUIRE;
              bitcnt_q <= '0;
            end
          end
          ST_LOCKED: begin
            if (hit) begin
              misscnt_q <= '0;
            end else begin
              error_q       <= 1'b1;
              error_count_q <= error_count_d;
              if (misscnt_q == MISS_LAST) begin
                state_q    <= ST_ACQUIRE;
                locked_q   <= 1'b0;
                bitcnt_q   <= '0;
                matchcnt_q <= '0;
                misscnt_q  <= '0;
              end else begin
                misscnt_q <= misscnt_q + 1'b1;
              end
            end
          end
          default: state_q <= ST_ACQUIRE;
        endcase
      end
      // Placed last so it overrides a same-cycle increment; lock is untouched.
      if (clear) begin
        error_count_q <= '0;
        misscnt_q     <= '0;
      end
    end
  end

  assign locked      = locked_q;
  assign error       = error_q;
  assign error_count = error_count_q;
  assign state       = state_q;

endmodule
